// File: rtl/synth_pkg.sv
// Shared sample-domain constants and helpers for the synth datapath.
// Saturation clamps any wide signed value into the 16-bit sample range.
package synth_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic signed [31:0] SAMPLE_MAX = 32'sd32767;
  localparam logic signed [31:0] SAMPLE_MIN = -32'sd32768;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > SAMPLE_MAX)      r = SAMPLE_MAX[SAMPLE_W-1:0];
    else if (v < SAMPLE_MIN) r = SAMPLE_MIN[SAMPLE_W-1:0];
    else                     r = v[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mix_out_reg.sv
// 1-entry valid/ready output buffer; a load overwrites any unaccepted sample and
// raises sticky overrun unless that sample is being accepted on the same edge.
module mix_out_reg
  import synth_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_vld,
  input  logic signed [SAMPLE_W-1:0] load_dat,
  input  logic                       clear_flags,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic                       overrun
);

  logic                       out_valid_q, out_valid_d;
  logic signed [SAMPLE_W-1:0] out_sample_q, out_sample_d;
  logic                       overrun_q, overrun_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    overrun_d    = overrun_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load_vld) begin
      out_valid_d  = 1'b1;
      out_sample_d = load_dat;
    end
    if (clear_flags) overrun_d = 1'b0;
    // set beats clear when both land in the same cycle
    if (load_vld && out_valid_q && !out_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/voice_mixer.sv
// Sums one frame of time-multiplexed voice samples, scales by GAIN_SHIFT and saturates;
// the mix appears 1 clock after the in_last beat. Input is never backpressured.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 16,
  parameter int GAIN_SHIFT  = 4,
  parameter int VOICE_IDX_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic [VOICE_IDX_W-1:0]     voice_index,
  input  logic                       in_last,
  input  logic [NUM_VOICES-1:0]      mute_mask,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       clear_flags
);

  localparam int LOG_NV = clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + LOG_NV;
  localparam int CNT_W  = LOG_NV + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        voice_cnt_q, voice_cnt_d;
  logic                    frame_err_q, frame_err_d;

  logic                       voice_live;
  logic signed [ACC_W-1:0]    contrib;
  logic signed [ACC_W-1:0]    total;
  logic signed [ACC_W-1:0]    scaled;
  logic signed [SAMPLE_W-1:0] mix;
  logic                       frame_done;

  // Out-of-range indices match no voice, so they fall through as silent.
  always_comb begin
    voice_live = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (32'(voice_index) == v) voice_live = !mute_mask[v];
    end
    contrib = voice_live ? ACC_W'(in_sample) : '0;
    total   = acc_q + contrib;
    scaled  = total >>> GAIN_SHIFT;
    mix     = sat16(32'(scaled));
  end

  assign frame_done = in_valid && in_last;

  always_comb begin
    acc_d       = acc_q;
    voice_cnt_d = voice_cnt_q;
    frame_err_d = frame_err_q;
    if (clear_flags) frame_err_d = 1'b0;
    if (in_valid) begin
      if (in_last) begin
        acc_d       = '0;
        voice_cnt_d = '0;
        if (32'(voice_cnt_q) + 1 != NUM_VOICES) frame_err_d = 1'b1;
      end else begin
        acc_d = total;
        if (voice_cnt_q != '1) voice_cnt_d = voice_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      voice_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      voice_cnt_q <= voice_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  mix_out_reg u_out (
    .clk         (clk),
    .reset       (reset),
    .load_vld    (frame_done),
    .load_dat    (mix),
    .clear_flags (clear_flags),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_sample  (out_sample),
    .overrun     (overrun)
  );

endmodule
